// File: rtl/rs_dispatch_unit_pkg.sv
// Shared types for the reservation-station dispatch path: dispatch/RS entry layouts and helpers.
package rs_dispatch_unit_pkg;

    localparam int unsigned PHY_REG_NUM = 32;
    localparam int unsigned PREG_W      = $clog2(PHY_REG_NUM);
    localparam int unsigned ROB_W       = 6;
    localparam int unsigned WB_WIDTH    = 2;

    typedef logic [PREG_W-1:0] preg_t;

    typedef struct packed {
        logic [3:0] fu_sel;
        logic [3:0] op;
    } OptionCodeSt;

    typedef struct packed {
        logic             valid;
        preg_t            psrc0;
        logic             psrc0_valid;
        preg_t            psrc1;
        logic             psrc1_valid;
        preg_t            pdest;
        logic             pdest_valid;
        logic [ROB_W-1:0] rob_idx;
        logic             position_bit;
    } DispatchInstSt;

    typedef struct packed {
        logic             valid;
        logic             issued;
        logic [ROB_W-1:0] rob_idx;
        logic             position_bit;
        preg_t            psrc0;
        logic             psrc0_ready;
        preg_t            psrc1;
        logic             psrc1_ready;
        preg_t            pdest;
        logic             pdest_valid;
    } RsBaseSt;

    function automatic RsBaseSt dis2rs(DispatchInstSt inst, logic r0, logic r1);
        RsBaseSt rs;
        rs              = '0;
        rs.valid        = 1'b1;
        rs.issued       = 1'b0;
        rs.rob_idx      = inst.rob_idx;
        rs.position_bit = inst.position_bit;
        rs.psrc0        = inst.psrc0;
        rs.psrc0_ready  = r0;
        rs.psrc1        = inst.psrc1;
        rs.psrc1_ready  = r1;
        rs.pdest        = inst.pdest;
        rs.pdest_valid  = inst.pdest_valid;
        return rs;
    endfunction

    function automatic logic wb_hit(logic [WB_WIDTH-1:0] wb, preg_t [WB_WIDTH-1:0] wb_pdest,
                                    preg_t preg);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < WB_WIDTH; i++) begin
            hit = hit | (wb[i] & (wb_pdest[i] == preg));
        end
        return hit;
    endfunction

endpackage

// File: rtl/rs_dispatch_unit_if.sv
// RS write bus: per-bank entry, option code and the wr_valid/wr_ready handshake.
interface rs_dispatch_unit_if #(
    parameter int unsigned BANK_NUM    = 2,
    parameter type         OPTION_CODE = rs_dispatch_unit_pkg::OptionCodeSt
);
    rs_dispatch_unit_pkg::RsBaseSt [BANK_NUM-1:0] rs_base;
    OPTION_CODE [BANK_NUM-1:0]                    rs_oc;
    logic [BANK_NUM-1:0]                          wr_valid;
    logic [BANK_NUM-1:0]                          wr_ready;

    modport master (output rs_base, output rs_oc, output wr_valid, input wr_ready);
    modport slave  (input rs_base, input rs_oc, input wr_valid, output wr_ready);
endinterface

// File: rtl/rs_dispatch_fifo.sv
// Per-bank skid FIFO toward one RS bank; stored entries and the head snoop writeback.
module rs_dispatch_fifo
    import rs_dispatch_unit_pkg::*;
#(
    parameter int unsigned BUF_DEPTH   = 4,
    parameter type         OPTION_CODE = OptionCodeSt
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  RsBaseSt              push_base_i,
    input  OPTION_CODE           push_oc_i,
    input  logic                 wr_ready_i,
    input  logic [WB_WIDTH-1:0]  wb_i,
    input  preg_t [WB_WIDTH-1:0] wb_pdest_i,
    output RsBaseSt              rs_base_o,
    output OPTION_CODE           rs_oc_o,
    output logic                 wr_valid_o,
    output logic                 full_o
);
    localparam int unsigned AW = $clog2(BUF_DEPTH);

    RsBaseSt    ent_q [BUF_DEPTH];
    OPTION_CODE oc_q  [BUF_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          empty, pop;
    RsBaseSt       head;

    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop        = ~empty & wr_ready_i;
    assign wr_valid_o = ~empty;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)               rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // The pushed slot is always free, so the push write never collides with a live snoop.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (wb_hit(wb_i, wb_pdest_i, ent_q[i].psrc0)) ent_q[i].psrc0_ready <= 1'b1;
            if (wb_hit(wb_i, wb_pdest_i, ent_q[i].psrc1)) ent_q[i].psrc1_ready <= 1'b1;
        end
        if (push_i && !full_o && !flush_i && !rst) begin
            ent_q[wr_idx] <= push_base_i;
            oc_q[wr_idx]  <= push_oc_i;
        end
    end

    always_comb begin
        head             = ent_q[rd_idx];
        head.psrc0_ready = head.psrc0_ready | wb_hit(wb_i, wb_pdest_i, head.psrc0);
        head.psrc1_ready = head.psrc1_ready | wb_hit(wb_i, wb_pdest_i, head.psrc1);
        rs_base_o        = empty ? '0 : head;
        rs_oc_o          = empty ? '0 : oc_q[rd_idx];
    end

endmodule

// File: rtl/rs_dispatch_unit.sv
// Dispatch producer: busy table, round-robin bank steering and per-bank RS write FIFOs.
module rs_dispatch_unit
    import rs_dispatch_unit_pkg::*;
#(
    parameter int unsigned BANK_NUM    = 2,
    parameter int unsigned BUF_DEPTH   = 4,
    parameter type         OPTION_CODE = OptionCodeSt
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  DispatchInstSt [BANK_NUM-1:0] dis_inst_i,
    input  OPTION_CODE [BANK_NUM-1:0]    dis_oc_i,
    input  logic                         dis_valid_i,
    output logic                         dis_ready_o,
    input  logic [WB_WIDTH-1:0]          wb_i,
    input  preg_t [WB_WIDTH-1:0]         wb_pdest_i,
    rs_dispatch_unit_if.master           rs_wr_io
);
    localparam int unsigned BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

    logic [BANK_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PHY_REG_NUM-1:0]    busy_q, busy_d;
    logic [PHY_REG_NUM-1:0]    preg_ready;
    logic                      accept;
    logic [BANK_NUM-1:0]       bank_full, bank_push, bank_valid;
    RsBaseSt [BANK_NUM-1:0]    bank_base, bank_out_base;
    OPTION_CODE [BANK_NUM-1:0] bank_oc, bank_out_oc;

    assign dis_ready_o = ~|bank_full;
    assign accept      = dis_valid_i & dis_ready_o;

    always_comb begin
        for (int p = 0; p < PHY_REG_NUM; p++) begin
            preg_ready[p] = ~busy_q[p] | (p == 0) | wb_hit(wb_i, wb_pdest_i, preg_t'(p));
        end
    end

    // k-th valid lane goes to bank (rr + k) % BANK_NUM; earlier lanes' pdest shadow later sources.
    always_comb begin
        int unsigned       k;
        logic [BANK_W-1:0] bank;
        logic              r0, r1;
        bank_push = '0;
        bank_base = '0;
        bank_oc   = '0;
        k         = 0;
        bank      = '0;
        r0        = 1'b0;
        r1        = 1'b0;
        for (int l = 0; l < BANK_NUM; l++) begin
            if (dis_inst_i[l].valid) begin
                bank = BANK_W'((int'(rr_ptr_q) + k) % BANK_NUM);
                r0   = ~dis_inst_i[l].psrc0_valid | preg_ready[dis_inst_i[l].psrc0];
                r1   = ~dis_inst_i[l].psrc1_valid | preg_ready[dis_inst_i[l].psrc1];
                for (int j = 0; j < l; j++) begin
                    if (dis_inst_i[j].valid && dis_inst_i[j].pdest_valid) begin
                        if (dis_inst_i[j].pdest == dis_inst_i[l].psrc0) r0 = 1'b0;
                        if (dis_inst_i[j].pdest == dis_inst_i[l].psrc1) r1 = 1'b0;
                    end
                end
                bank_push[bank] = accept;
                bank_base[bank] = dis2rs(dis_inst_i[l], r0, r1);
                bank_oc[bank]   = dis_oc_i[l];
                k++;
            end
        end
        rr_ptr_d = accept ? BANK_W'((int'(rr_ptr_q) + k) % BANK_NUM) : rr_ptr_q;
    end

    // Allocation is applied after writeback so it wins on the same preg.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < WB_WIDTH; w++) begin
            if (wb_i[w]) busy_d[wb_pdest_i[w]] = 1'b0;
        end
        if (accept) begin
            for (int l = 0; l < BANK_NUM; l++) begin
                if (dis_inst_i[l].valid && dis_inst_i[l].pdest_valid) begin
                    busy_d[dis_inst_i[l].pdest] = 1'b1;
                end
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            busy_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            busy_q   <= busy_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        rs_dispatch_fifo #(
            .BUF_DEPTH   (BUF_DEPTH),
            .OPTION_CODE (OPTION_CODE)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .flush_i     (flush_i),
            .push_i      (bank_push[b]),
            .push_base_i (bank_base[b]),
            .push_oc_i   (bank_oc[b]),
            .wr_ready_i  (rs_wr_io.wr_ready[b]),
            .wb_i        (wb_i),
            .wb_pdest_i  (wb_pdest_i),
            .rs_base_o   (bank_out_base[b]),
            .rs_oc_o     (bank_out_oc[b]),
            .wr_valid_o  (bank_valid[b]),
            .full_o      (bank_full[b])
        );
    end

    assign rs_wr_io.rs_base  = bank_out_base;
    assign rs_wr_io.rs_oc    = bank_out_oc;
    assign rs_wr_io.wr_valid = bank_valid;

endmodule

// File: tb/tb_rs_dispatch_unit.sv
// Bench for rs_dispatch_unit: queue-level model checked every cycle plus directed literal checks.
module tb_rs_dispatch_unit;
    import rs_dispatch_unit_pkg::*;

    localparam int NB = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush_i;
    DispatchInstSt [NB-1:0] dis_inst;
    OptionCodeSt [NB-1:0]   dis_oc;
    logic                   dis_valid;
    logic                   dis_ready;
    logic [WB_WIDTH-1:0]    wb;
    preg_t [WB_WIDTH-1:0]   wb_pdest;
    logic [NB-1:0]          wr_ready;

    always #5 clk = ~clk;

    rs_dispatch_unit_if #(.BANK_NUM(NB), .OPTION_CODE(OptionCodeSt)) rs_wr ();
    assign rs_wr.wr_ready = wr_ready;

    rs_dispatch_unit #(
        .BANK_NUM    (NB),
        .BUF_DEPTH   (DEPTH),
        .OPTION_CODE (OptionCodeSt)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .dis_inst_i  (dis_inst),
        .dis_oc_i    (dis_oc),
        .dis_valid_i (dis_valid),
        .dis_ready_o (dis_ready),
        .wb_i        (wb),
        .wb_pdest_i  (wb_pdest),
        .rs_wr_io    (rs_wr)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: per-bank queues of expected entries, a busy set and a round-robin counter.
    typedef struct packed {
        RsBaseSt     b;
        OptionCodeSt oc;
    } ent_t;

    ent_t mq [NB][$];
    logic [PHY_REG_NUM-1:0] m_busy = '0;
    int m_rr = 0;

    function automatic logic m_wbm(preg_t p);
        for (int i = 0; i < WB_WIDTH; i++) if (wb[i] && wb_pdest[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_rdy(logic v, preg_t p);
        return !v || p == 0 || !m_busy[p] || m_wbm(p);
    endfunction

    function automatic logic m_ready();
        for (int b = 0; b < NB; b++) if (mq[b].size() >= DEPTH) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        logic acc, r0, r1;
        int k;
        ent_t e;
        logic [PHY_REG_NUM-1:0] nb;
        if (rst || flush_i) begin
            for (int b = 0; b < NB; b++) mq[b].delete();
            m_busy = '0;
            m_rr = 0;
        end else begin
            acc = dis_valid && m_ready();
            for (int b = 0; b < NB; b++)
                if (mq[b].size() > 0 && wr_ready[b]) void'(mq[b].pop_front());
            for (int b = 0; b < NB; b++) begin
                for (int i = 0; i < mq[b].size(); i++) begin
                    e = mq[b][i];
                    if (m_wbm(e.b.psrc0)) e.b.psrc0_ready = 1'b1;
                    if (m_wbm(e.b.psrc1)) e.b.psrc1_ready = 1'b1;
                    mq[b][i] = e;
                end
            end
            nb = m_busy;
            for (int w = 0; w < WB_WIDTH; w++) if (wb[w]) nb[wb_pdest[w]] = 1'b0;
            if (acc) begin
                k = 0;
                for (int l = 0; l < NB; l++) begin
                    if (dis_inst[l].valid) begin
                        r0 = m_rdy(dis_inst[l].psrc0_valid, dis_inst[l].psrc0);
                        r1 = m_rdy(dis_inst[l].psrc1_valid, dis_inst[l].psrc1);
                        for (int j = 0; j < l; j++) begin
                            if (dis_inst[j].valid && dis_inst[j].pdest_valid) begin
                                if (dis_inst[j].pdest == dis_inst[l].psrc0) r0 = 1'b0;
                                if (dis_inst[j].pdest == dis_inst[l].psrc1) r1 = 1'b0;
                            end
                        end
                        e = '0;
                        e.b.valid        = 1'b1;
                        e.b.rob_idx      = dis_inst[l].rob_idx;
                        e.b.position_bit = dis_inst[l].position_bit;
                        e.b.psrc0        = dis_inst[l].psrc0;
                        e.b.psrc0_ready  = r0;
                        e.b.psrc1        = dis_inst[l].psrc1;
                        e.b.psrc1_ready  = r1;
                        e.b.pdest        = dis_inst[l].pdest;
                        e.b.pdest_valid  = dis_inst[l].pdest_valid;
                        e.oc             = dis_oc[l];
                        mq[(m_rr + k) % NB].push_back(e);
                        if (dis_inst[l].pdest_valid && dis_inst[l].pdest != 0)
                            nb[dis_inst[l].pdest] = 1'b1;
                        k++;
                    end
                end
                m_rr = (m_rr + k) % NB;
            end
            m_busy = nb;
        end
    end

    always @(negedge clk) begin
        RsBaseSt     eb;
        OptionCodeSt eo;
        logic        ev;
        if (!rst) begin
            chk("dis_ready", dis_ready, m_ready());
            for (int b = 0; b < NB; b++) begin
                ev = mq[b].size() > 0;
                eb = '0;
                eo = '0;
                if (ev) begin
                    eb = mq[b][0].b;
                    eo = mq[b][0].oc;
                    eb.psrc0_ready = eb.psrc0_ready | m_wbm(eb.psrc0);
                    eb.psrc1_ready = eb.psrc1_ready | m_wbm(eb.psrc1);
                end
                chk($sformatf("wr_valid[%0d]", b), rs_wr.wr_valid[b], ev);
                chk($sformatf("rs_base[%0d]", b), rs_wr.rs_base[b], eb);
                chk($sformatf("rs_oc[%0d]", b), rs_wr.rs_oc[b], eo);
            end
        end
    end

    task automatic idle_in();
        dis_valid = 1'b0;
        dis_inst  = '0;
        dis_oc    = '0;
        wb        = '0;
        wb_pdest  = '0;
        flush_i   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic DispatchInstSt mk(int s0, bit s0v, int s1, bit s1v, int d, bit dv, int rob);
        DispatchInstSt x;
        x.valid        = 1'b1;
        x.psrc0        = preg_t'(s0);
        x.psrc0_valid  = s0v;
        x.psrc1        = preg_t'(s1);
        x.psrc1_valid  = s1v;
        x.pdest        = preg_t'(d);
        x.pdest_valid  = dv;
        x.rob_idx      = ROB_W'(rob);
        x.position_bit = rob[0];
        return x;
    endfunction

    task automatic send(DispatchInstSt l0, DispatchInstSt l1);
        dis_inst[0] = l0;
        dis_inst[1] = l1;
        dis_oc[0]   = {4'h1, l0.rob_idx[3:0]};
        dis_oc[1]   = {4'h2, l1.rob_idx[3:0]};
        dis_valid   = 1'b1;
        step();
        dis_valid = 1'b0;
        dis_inst  = '0;
        dis_oc    = '0;
        #1;
    endtask

    int got0[$];
    int got1[$];

    initial begin
        idle_in();
        wr_ready = '1;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // 1: reset state, lone lane with a never-written source
        chk("reset wr_valid", rs_wr.wr_valid, 2'b00);
        chk("reset dis_ready", dis_ready, 1'b1);
        chk("reset rs_base0", rs_wr.rs_base[0], '0);
        send(mk(9, 1, 0, 0, 0, 0, 1), '0);
        chk("t1 wr_valid", rs_wr.wr_valid, 2'b01);
        chk("t1 psrc0_ready", rs_wr.rs_base[0].psrc0_ready, 1'b1);
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;

        // 2: intra-group RAW
        wr_ready = '0;
        send(mk(0, 0, 0, 0, 5, 1, 2), mk(5, 1, 3, 1, 0, 0, 3));
        chk("t2 wr_valid", rs_wr.wr_valid, 2'b11);
        chk("t2 b0 rob", rs_wr.rs_base[0].rob_idx, 2);
        chk("t2 b1 rob", rs_wr.rs_base[1].rob_idx, 3);
        chk("t2 raw psrc0_ready", rs_wr.rs_base[1].psrc0_ready, 1'b0);
        chk("t2 psrc1_ready", rs_wr.rs_base[1].psrc1_ready, 1'b1);
        wr_ready = '1;
        step();
        wr_ready = '0;

        // 4: single-lane groups rotate banks 0,1,0 then 1
        send(mk(1, 1, 0, 0, 0, 0, 10), '0);
        send('0, mk(1, 1, 0, 0, 0, 0, 11));
        send(mk(1, 1, 0, 0, 0, 0, 12), '0);
        chk("t4 b0 rob", rs_wr.rs_base[0].rob_idx, 10);
        chk("t4 b1 rob", rs_wr.rs_base[1].rob_idx, 11);
        wr_ready = 2'b01;
        step();
        wr_ready = '0;
        chk("t4 b0 next rob", rs_wr.rs_base[0].rob_idx, 12);
        send(mk(1, 1, 0, 0, 0, 0, 13), '0);
        wr_ready = 2'b10;
        step();
        wr_ready = '0;
        chk("t4 rr=1 b1 rob", rs_wr.rs_base[1].rob_idx, 13);
        wr_ready = '1;
        repeat (2) step();

        // 3: wb bypass onto held head, then retained after wb drops
        send(mk(0, 0, 0, 0, 7, 1, 20), mk(0, 0, 0, 0, 0, 0, 21));
        step();
        wr_ready = 2'b10;
        send(mk(7, 1, 0, 0, 0, 0, 22), '0);
        chk("t3 psrc0 busy", rs_wr.rs_base[0].psrc0_ready, 1'b0);
        step();
        wb[1]       = 1'b1;
        wb_pdest[1] = 7;
        #1;
        chk("t3 bypass", rs_wr.rs_base[0].psrc0_ready, 1'b1);
        step();
        wb = '0;
        wb_pdest = '0;
        #1;
        chk("t3 held", rs_wr.rs_base[0].psrc0_ready, 1'b1);
        chk("t3 still valid", rs_wr.wr_valid[0], 1'b1);
        wr_ready = '1;
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;

        // 5: back-pressure until full, then ordered drain
        wr_ready = '0;
        for (int g = 0; g < 4; g++) begin
            send(mk(0, 0, 0, 0, 0, 0, 30 + 2 * g), mk(0, 0, 0, 0, 0, 0, 31 + 2 * g));
            if (g == 2) chk("t5 ready after 3", dis_ready, 1'b1);
        end
        chk("t5 full", dis_ready, 1'b0);
        send(mk(0, 0, 0, 0, 0, 0, 40), mk(0, 0, 0, 0, 0, 0, 41));
        wr_ready = '1;
        for (int c = 0; c < 12; c++) begin
            if (rs_wr.wr_valid[0]) got0.push_back(int'(rs_wr.rs_base[0].rob_idx));
            if (rs_wr.wr_valid[1]) got1.push_back(int'(rs_wr.rs_base[1].rob_idx));
            step();
        end
        chk("t5 b0 count", got0.size(), 4);
        chk("t5 b1 count", got1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5 b0 order %0d", i), (i < got0.size()) ? got0[i] : -1, 30 + 2 * i);
            chk($sformatf("t5 b1 order %0d", i), (i < got1.size()) ? got1[i] : -1, 31 + 2 * i);
        end

        // 6: flush clears queues, rr and busy table, beating a same-cycle dispatch
        wr_ready = '0;
        send(mk(0, 0, 0, 0, 12, 1, 50), '0);
        send(mk(1, 1, 0, 0, 0, 0, 51), '0);
        send(mk(1, 1, 0, 0, 0, 0, 52), '0);
        chk("t6 queued", rs_wr.wr_valid, 2'b11);
        flush_i     = 1'b1;
        dis_valid   = 1'b1;
        dis_inst[0] = mk(12, 1, 0, 0, 0, 0, 53);
        step();
        idle_in();
        #1;
        chk("t6 flushed wr_valid", rs_wr.wr_valid, 2'b00);
        chk("t6 flushed ready", dis_ready, 1'b1);
        send(mk(12, 1, 0, 0, 0, 0, 54), '0);
        chk("t6 rr=0", rs_wr.wr_valid, 2'b01);
        chk("t6 preg12 ready", rs_wr.rs_base[0].psrc0_ready, 1'b1);
        wr_ready = '1;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
